// File: rtl/encoder_4x2_pkg.sv
// Shared widths, types and reset constant for the clocked 4-to-2 priority encoder.
package encoder_4x2_pkg;

  localparam int X_W = 4;
  localparam int Y_W = 2;

  typedef logic [X_W-1:0] req_t;
  typedef logic [Y_W-1:0] idx_t;

  localparam idx_t IDX_RESET = '0;

endpackage : encoder_4x2_pkg

// File: rtl/encoder_4x2_core.sv
// Combinational priority core: index of the highest set request bit, plus presence flags.
// The multi flag exists only when ENCODER_4X2_ERR_EN is defined.
module encoder_4x2_core
  import encoder_4x2_pkg::*;
(
  input  logic [X_W-1:0] x,
  output logic [Y_W-1:0] idx,
  output logic           any
`ifdef ENCODER_4X2_ERR_EN
  ,
  output logic           multi
`endif
);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    idx = IDX_RESET;
    if (x[3])      idx = 2'd3;
    else if (x[2]) idx = 2'd2;
    else if (x[1]) idx = 2'd1;
  end

  assign any = |x;

`ifdef ENCODER_4X2_ERR_EN
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi = |(x & (x - 1'b1));
`endif

endmodule : encoder_4x2_core

// File: rtl/encoder_4x2.sv
// Clocked 4-to-2 priority encoder with enable; one cycle of latency, outputs registered.
// Optional err output (more than one request bit set) is built when ENCODER_4X2_ERR_EN is defined.
module encoder_4x2
  import encoder_4x2_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic [X_W-1:0] x,
  input  logic           en,
  output logic [Y_W-1:0] y,
  output logic           valid
`ifdef ENCODER_4X2_ERR_EN
  ,
  output logic           err
`endif
);

  logic [Y_W-1:0] idx;
  logic           any;
  logic [Y_W-1:0] y_d, y_q;
  logic           valid_d, valid_q;

`ifdef ENCODER_4X2_ERR_EN
  logic multi;
  logic err_d, err_q;
`endif

  encoder_4x2_core u_core (
    .x    (x),
    .idx  (idx),
    .any  (any)
`ifdef ENCODER_4X2_ERR_EN
    ,
    .multi(multi)
`endif
  );

  // The index holds while disabled; the flags only describe the current enabled edge.
  always_comb begin
    y_d     = en ? idx : y_q;
    valid_d = en & any;
  end

`ifdef ENCODER_4X2_ERR_EN
  assign err_d = en & multi;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= IDX_RESET;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

`ifdef ENCODER_4X2_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`endif

  assign y     = y_q;
  assign valid = valid_q;

endmodule : encoder_4x2

// File: tb/tb_encoder_4x2.sv
// Self-checking bench for encoder_4x2: directed sweeps plus random stimulus against a behavioural model.
module tb_encoder_4x2;

  logic       clk;
  logic       rst_n;
  logic [3:0] x;
  logic       en;
  logic [1:0] y;
  logic       valid;
`ifdef ENCODER_4X2_ERR_EN
  logic       err;
`endif

  int n_cmp;
  int n_bad;

  // Behavioural model of the registered outputs.
  logic [1:0] m_y;
  logic       m_valid;
  logic       m_err;

  encoder_4x2 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .x    (x),
    .en   (en),
    .y    (y),
    .valid(valid)
`ifdef ENCODER_4X2_ERR_EN
    ,
    .err  (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_index(input logic [3:0] v);
    int r = 0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r[1:0];
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".y"}, {2'b00, y}, {2'b00, m_y});
    check({tag, ".valid"}, {3'b000, valid}, {3'b000, m_valid});
`ifdef ENCODER_4X2_ERR_EN
    check({tag, ".err"}, {3'b000, err}, {3'b000, m_err});
`endif
  endtask

  task automatic model_reset();
    m_y     = 2'b00;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  // Drive on the falling edge, let one rising edge sample, check just after it.
  task automatic step(input logic [3:0] xv, input logic env, input string tag);
    @(negedge clk);
    x  = xv;
    en = env;
    @(posedge clk);
    #1;
    if (env) begin
      m_y     = ref_index(xv);
      m_valid = (xv != 0);
      m_err   = ($countones(xv) > 1);
    end else begin
      m_valid = 1'b0;
      m_err   = 1'b0;
    end
    check_outputs(tag);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    x     = 4'h0;
    en    = 1'b0;
    rst_n = 1'b0;
    model_reset();

    #12;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // One-hot sweep.
    for (int i = 0; i < 4; i++) step(4'b0001 << i, 1'b1, "onehot");
    check("onehot_top", {2'b00, y}, 4'd3);

    // Incrementing sweep with wrap.
    for (int i = 0; i < 32; i++) step(i[3:0], 1'b1, "sweep");

    // Enable hold.
    step(4'b0100, 1'b1, "hold_load");
    check("hold_load_y", {2'b00, y}, 4'd2);
    step(4'b1000, 1'b0, "hold");
    check("hold_y", {2'b00, y}, 4'd2);
    step(4'b1000, 1'b0, "hold2");

    // Multi-bit request and back to a single bit.
    step(4'b1010, 1'b1, "multi");
    check("multi_y", {2'b00, y}, 4'd3);
    step(4'b0010, 1'b1, "single");

    // Zero with enable after a valid encode.
    step(4'b1111, 1'b1, "pre_zero");
    step(4'b0000, 1'b1, "zero");
    check("zero_y", {2'b00, y}, 4'd0);

    // Asynchronous reset mid-cycle, then held across an enabled edge.
    step(4'b1100, 1'b1, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    x  = 4'b1111;
    en = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("rst_held");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      logic [3:0] rx;
      logic       ren;
      rx  = 4'($urandom_range(0, 15));
      ren = ($urandom_range(0, 3) != 0);
      step(rx, ren, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_encoder_4x2
